top_out_monitor: RTL and testbench
==================================

# top_out_monitor

Downstream capture stage for the chip top level. It waits for the core's `passed` flag, then compresses `NUM_SAMPLES` consecutive cycles of the top-level output buses (`out_small`, `out_quad`, `out_wide`) into a 64-bit MISR signature. It compares the signature to an expected constant and reports done, match and timeout status to the bench or SoC wrapper, so a whole run reduces to one pass/fail word.

## Interface
- `NUM_SAMPLES`, default 16: cycles compressed per run; legal range 1..65535.
- `TIMEOUT`, default 1023: maximum cycles spent waiting for `passed`; legal range 1..65535.
- `EXPECT_SIG`, default 64'h0: expected final signature.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle run request.
- `passed` in 1: core completion flag.
- `out_small` in 2: top-level small output bus.
- `out_quad` in 40: top-level quad output bus.
- `out_wide` in 70: top-level wide output bus.
- `busy` out 1: high in WAIT_PASS, SAMPLE and CHECK.
- `done` out 1: high in DONE.
- `match` out 1: final signature equals `EXPECT_SIG`; valid while `done`.
- `timeout` out 1: `passed` was never seen within `TIMEOUT` cycles; valid while `done`.
- `signature` out 64: current MISR value.
- `sample_count` out 16: number of samples compressed in this run.

## Operation
- FSM states: IDLE, WAIT_PASS, SAMPLE, CHECK, DONE.
- IDLE:
  - `start`=1 → WAIT_PASS.
  - On the same edge: clear `signature`, `sample_count`, the wait counter, `match` and `timeout`.
- WAIT_PASS:
  - The wait counter increments every cycle that `passed`=0.
  - `passed`=1 → SAMPLE.
  - Otherwise, if the counter equals `TIMEOUT`-1 → DONE with `timeout`=1 and `match`=0.
  - If `passed` rises on the final wait cycle, `passed` wins and the FSM goes to SAMPLE.
- Sample word: D = {`out_small`, `out_wide`, `out_quad`}, 112 bits, zero-extended to 128.
  - F = D[127:64] ^ D[63:0].
- SAMPLE, every cycle:
  - `signature` ← {sig[62:0], sig[63]^sig[62]^sig[60]^sig[59]} ^ F.
  - `sample_count` increments.
  - When `sample_count` reaches `NUM_SAMPLES`-1 on this edge → CHECK.
  - Exactly `NUM_SAMPLES` words are compressed.
  - `passed` is ignored once in SAMPLE.
- CHECK: `match` ← (`signature` == `EXPECT_SIG`), then → DONE.
- DONE:
  - All status outputs hold.
  - `start`=1 → WAIT_PASS, with the same clears as from IDLE.
- `start` is ignored in WAIT_PASS, SAMPLE and CHECK.
- Reset asserted at any time, including mid-run:
  - FSM → IDLE.
  - All outputs 0; `signature` = 64'h0 and `sample_count` = 0.
  - No partial status survives reset.

## Timing
- Reset values: `busy`=0, `done`=0, `match`=0, `timeout`=0, `signature`=0, `sample_count`=0.
- Edge 0 samples `start`=1; `busy` goes high after edge 0.
- If `passed` is first seen high at edge k:
  - The first data sample is taken at edge k+1.
  - The last data sample is taken at edge k+`NUM_SAMPLES`.
  - CHECK occupies one cycle.
  - `done` goes high after edge k+`NUM_SAMPLES`+1, with `busy` low in the same cycle.
- Timeout path: `done` goes high `TIMEOUT` cycles after WAIT_PASS entry.
- Buses are sampled with no input registering, so they must be stable at the `clk` edge.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- All-zero stream:
  - Stimulus: `EXPECT_SIG`=0, `NUM_SAMPLES`=16, `passed` high 3 cycles after start, all buses 0.
  - Required: `signature`=64'h0, `sample_count`=16, `match`=1, `timeout`=0, `done` high 19 cycles after the start edge.
- Single sample:
  - Stimulus: `NUM_SAMPLES`=1, `out_quad`=40'h1, other buses 0, `passed` high immediately.
  - Required: `signature`=64'h1, `match`=1 when `EXPECT_SIG`=64'h1, `match`=0 when `EXPECT_SIG`=0.
- Fold check:
  - Stimulus: `NUM_SAMPLES`=1, `out_wide`=70'h1 << 24, other buses 0.
  - Required: D bit 64 set, so F=64'h1 and `signature`=64'h1.
- Timeout:
  - Stimulus: `TIMEOUT`=8, `passed` held 0.
  - Required: `done`=1, `timeout`=1, `match`=0 exactly 8 cycles after WAIT_PASS entry; `sample_count`=0.
  - Variant: `passed`=1 on wait cycle 8. Required: SAMPLE is entered and `timeout`=0.
- Reset mid-run:
  - Stimulus: assert `reset` for 1 cycle during SAMPLE after 5 samples.
  - Required: all outputs 0 immediately, asynchronously.
  - A subsequent `start` runs a full `NUM_SAMPLES` capture from `signature`=0.
- Restart and ignored start:
  - Stimulus: `start` pulses during SAMPLE, then again in DONE.
  - Required: the `start` in SAMPLE has no effect.
  - Required: the `start` in DONE clears status and re-enters WAIT_PASS on the next cycle with `done`=0.

Source files
------------

// File: rtl/top_out_monitor.sv
// Output-bus capture monitor: waits for the core's passed flag, folds NUM_SAMPLES
// cycles of the top-level buses into a 64-bit MISR and compares it to EXPECT_SIG.
module top_out_monitor #(
    parameter int          NUM_SAMPLES = 16,
    parameter int          TIMEOUT     = 1023,
    parameter logic [63:0] EXPECT_SIG  = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        passed,
    input  logic [1:0]  out_small,
    input  logic [39:0] out_quad,
    input  logic [69:0] out_wide,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        timeout,
    output logic [63:0] signature,
    output logic [15:0] sample_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [15:0] LP_LAST_SAMPLE = 16'(NUM_SAMPLES - 1);
    localparam logic [15:0] LP_LAST_WAIT   = 16'(TIMEOUT - 1);

    logic [2:0]   r_state;
    logic [15:0]  r_wait_cnt;
    logic [15:0]  r_count;
    logic [63:0]  r_sig;
    logic         r_match;
    logic         r_timeout;

    logic [127:0] w_data;
    logic [63:0]  w_fold;
    logic         w_fb;
    logic [63:0]  w_sig_next;

    // 112-bit sample word zero-extended, then folded to the 64-bit MISR width
    assign w_data     = {16'h0, out_small, out_wide, out_quad};
    assign w_fold     = w_data[127:64] ^ w_data[63:0];
    assign w_fb       = r_sig[63] ^ r_sig[62] ^ r_sig[60] ^ r_sig[59];
    assign w_sig_next = {r_sig[62:0], w_fb} ^ w_fold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_count    <= '0;
            r_sig      <= '0;
            r_match    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                        r_count    <= '0;
                        r_sig      <= '0;
                        r_match    <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // passed on the final wait cycle still wins over the timeout
                    if (passed) begin
                        r_state <= S_SAMPLE;
                    end else if (r_wait_cnt == LP_LAST_WAIT) begin
                        r_state   <= S_DONE;
                        r_timeout <= 1'b1;
                        r_match   <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                S_SAMPLE: begin
                    r_sig   <= w_sig_next;
                    r_count <= r_count + 16'd1;
                    if (r_count == LP_LAST_SAMPLE) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_match <= (r_sig == EXPECT_SIG);
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (r_state == S_WAIT) || (r_state == S_SAMPLE) || (r_state == S_CHECK);
    assign done         = (r_state == S_DONE);
    assign match        = r_match;
    assign timeout      = r_timeout;
    assign signature    = r_sig;
    assign sample_count = r_count;

endmodule

// File: tb/tb_top_out_monitor.sv
// Directed bench for top_out_monitor: three instances cover NUM_SAMPLES=16 and the
// single-sample configurations with EXPECT_SIG of 1 and 0.
module tb_top_out_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        passed;
    logic [1:0]  out_small;
    logic [39:0] out_quad;
    logic [69:0] out_wide;

    logic        a_busy, a_done, a_match, a_timeout;
    logic [63:0] a_sig;
    logic [15:0] a_cnt;
    logic        b_busy, b_done, b_match, b_timeout;
    logic [63:0] b_sig;
    logic [15:0] b_cnt;
    logic        c_busy, c_done, c_match, c_timeout;
    logic [63:0] c_sig;
    logic [15:0] c_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    top_out_monitor #(.NUM_SAMPLES(16), .TIMEOUT(8), .EXPECT_SIG(64'h0)) u_a (
        .clk(clk), .reset(reset), .start(start), .passed(passed),
        .out_small(out_small), .out_quad(out_quad), .out_wide(out_wide),
        .busy(a_busy), .done(a_done), .match(a_match), .timeout(a_timeout),
        .signature(a_sig), .sample_count(a_cnt)
    );

    top_out_monitor #(.NUM_SAMPLES(1), .TIMEOUT(8), .EXPECT_SIG(64'h1)) u_b (
        .clk(clk), .reset(reset), .start(start), .passed(passed),
        .out_small(out_small), .out_quad(out_quad), .out_wide(out_wide),
        .busy(b_busy), .done(b_done), .match(b_match), .timeout(b_timeout),
        .signature(b_sig), .sample_count(b_cnt)
    );

    top_out_monitor #(.NUM_SAMPLES(1), .TIMEOUT(8), .EXPECT_SIG(64'h0)) u_c (
        .clk(clk), .reset(reset), .start(start), .passed(passed),
        .out_small(out_small), .out_quad(out_quad), .out_wide(out_wide),
        .busy(c_busy), .done(c_done), .match(c_match), .timeout(c_timeout),
        .signature(c_sig), .sample_count(c_cnt)
    );

    // inputs change and outputs are observed 1 time unit after the rising edge
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // start at edge 0, passed seen at edge 1, single sample at edge 2, done after edge 3
    task automatic run_short();
        start = 1'b1;
        step();
        start  = 1'b0;
        passed = 1'b1;
        step();
        passed = 1'b0;
        step(2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        passed    = 1'b0;
        out_small = '0;
        out_quad  = '0;
        out_wide  = '0;
        #3;
        chk("rst_busy",  64'(a_busy),    64'h0);
        chk("rst_done",  64'(a_done),    64'h0);
        chk("rst_match", 64'(a_match),   64'h0);
        chk("rst_tmo",   64'(a_timeout), 64'h0);
        chk("rst_sig",   a_sig,          64'h0);
        chk("rst_cnt",   64'(a_cnt),     64'h0);
        step();
        reset = 1'b0;

        // all-zero stream: passed seen at edge 2, done after edge 19
        start = 1'b1;
        step();
        start = 1'b0;
        chk("z_busy_e0", 64'(a_busy), 64'h1);
        step();
        passed = 1'b1;
        step();
        passed = 1'b0;
        step(16);
        chk("z_done_e18", 64'(a_done), 64'h0);
        step();
        chk("z_done_e19", 64'(a_done),    64'h1);
        chk("z_busy_e19", 64'(a_busy),    64'h0);
        chk("z_sig",      a_sig,          64'h0);
        chk("z_cnt",      64'(a_cnt),     64'd16);
        chk("z_match",    64'(a_match),   64'h1);
        chk("z_tmo",      64'(a_timeout), 64'h0);

        // timeout from DONE restart; start clears done on the next cycle
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t_done_clr", 64'(a_done),  64'h0);
        chk("t_busy",     64'(a_busy),  64'h1);
        chk("t_match_clr",64'(a_match), 64'h0);
        step(7);
        chk("t_done_e7", 64'(a_done), 64'h0);
        step();
        chk("t_done_e8", 64'(a_done),    64'h1);
        chk("t_tmo",     64'(a_timeout), 64'h1);
        chk("t_match",   64'(a_match),   64'h0);
        chk("t_cnt",     64'(a_cnt),     64'h0);

        // passed on the last wait cycle wins; then start during SAMPLE is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        step(7);
        passed = 1'b1;
        step();
        passed = 1'b0;
        chk("v_busy", 64'(a_busy),    64'h1);
        chk("v_done", 64'(a_done),    64'h0);
        chk("v_tmo",  64'(a_timeout), 64'h0);
        out_quad = 40'h1;
        step();
        out_quad = 40'h0;
        chk("v_sig1", a_sig,      64'h1);
        chk("v_cnt1", 64'(a_cnt), 64'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("i_sig2", a_sig,      64'h2);
        chk("i_cnt2", 64'(a_cnt), 64'd2);
        step(14);
        chk("i_done_pre", 64'(a_done), 64'h0);
        step();
        chk("i_done",  64'(a_done),    64'h1);
        chk("i_sig",   a_sig,          64'h8000);
        chk("i_cnt",   64'(a_cnt),     64'd16);
        chk("i_match", 64'(a_match),   64'h0);
        chk("i_tmo",   64'(a_timeout), 64'h0);

        // reset mid-run after 5 samples of F=1: 1,3,7,F,1F
        start = 1'b1;
        step();
        start    = 1'b0;
        passed   = 1'b1;
        step();
        passed   = 1'b0;
        out_quad = 40'h1;
        step(5);
        chk("r_sig5", a_sig,      64'h1F);
        chk("r_cnt5", 64'(a_cnt), 64'd5);
        reset = 1'b1;
        #1;
        chk("r_busy", 64'(a_busy), 64'h0);
        chk("r_sig0", a_sig,       64'h0);
        chk("r_cnt0", 64'(a_cnt),  64'h0);
        step();
        reset    = 1'b0;
        out_quad = 40'h0;
        start    = 1'b1;
        step();
        start  = 1'b0;
        passed = 1'b1;
        step();
        passed = 1'b0;
        step(16);
        chk("r2_done_pre", 64'(a_done), 64'h0);
        step();
        chk("r2_done",  64'(a_done),  64'h1);
        chk("r2_sig",   a_sig,        64'h0);
        chk("r2_cnt",   64'(a_cnt),   64'd16);
        chk("r2_match", 64'(a_match), 64'h1);

        // single sample, out_quad=1
        do_reset();
        out_quad = 40'h1;
        run_short();
        chk("s_b_done",  64'(b_done),  64'h1);
        chk("s_b_sig",   b_sig,        64'h1);
        chk("s_b_cnt",   64'(b_cnt),   64'd1);
        chk("s_b_match", 64'(b_match), 64'h1);
        chk("s_c_sig",   c_sig,        64'h1);
        chk("s_c_match", 64'(c_match), 64'h0);

        // fold: wide bit 24 lands at D[64] and folds onto bit 0
        out_quad = 40'h0;
        out_wide = 70'h1 << 24;
        run_short();
        chk("f_b_sig",   b_sig,        64'h1);
        chk("f_b_match", 64'(b_match), 64'h1);

        // out_small bit 0 is D[110], folded to bit 46
        out_wide  = '0;
        out_small = 2'b01;
        run_short();
        chk("sm_c_sig",   c_sig,        64'h0000_4000_0000_0000);
        chk("sm_c_match", 64'(c_match), 64'h0);
        chk("sm_c_done",  64'(c_done),  64'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
